inst_prefetch_queue: RTL and testbench
======================================

// Module: inst_prefetch_queue
// PURPOSE
//  Instruction prefetch stage between the instruction ROM and the decode/control stage.
//  - Fetches sequentially from its own fetch PC and buffers up to DEPTH instructions.
//  - Each entry is {instruction, PC, PC+4} and is handed to decode over a valid/ready handshake.
//  - A redirect (branch, jump, JR, ILLOP/XADR exception, IRQ) flushes the queue and restarts fetch.
// PARAMETERS
//  DEPTH     4             queue entries; power of two, >=2
//  RESET_PC  32'h80000000  fetch address after reset (kernel bit set)
// PORTS
//  Clk         in   1   sole clock, rising edge
//  Reset       in   1   asynchronous, active-low reset
//  RomRd       out  1   ROM read strobe; data returns exactly 1 cycle later
//  RomAddr     out  32  ROM byte address, [1:0]=0
//  RomData     in   32  ROM read data, valid the cycle after RomRd
//  Redirect    in   1   flush queue and refetch from RedirectPC
//  RedirectPC  in   32  new fetch address; [1:0] forced to 0
//  InstValid   out  1   head entry valid
//  InstReady   in   1   decode accepts head this cycle
//  Instruct    out  32  head instruction
//  InstPC      out  32  head instruction address
//  InstPC4     out  32  {InstPC[31], InstPC[30:0]+31'd4}
//  Count       out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (async, Reset=0):
//    - FetchPC=RESET_PC, Count=0, in-flight=0.
//    - RomRd=0, InstValid=0; Instruct, InstPC and InstPC4 read 0.
//  - Issue: RomRd=1 when Count + in-flight + 1 <= DEPTH and Redirect=0.
//    - Pop credit is not counted, so the queue never overflows.
//    - RomAddr=FetchPC (registered), then FetchPC <= {FetchPC[31], FetchPC[30:0]+4}.
//    - Bit 31 (kernel bit) never changes on increment; [30:0] wraps to 0 past 31'h7FFFFFFC.
//  - Fill:
//    - A response arriving the cycle after a non-squashed issue is written at the tail.
//    - The entry stores {RomData, address issued, address+4}.
//    - At most one response is in flight.
//  - Latency: after Reset rises, the first RomRd is on the next edge.
//    - Its data is enqueued one cycle later.
//    - InstValid=1 two cycles after first RomRd.
//    - Sustained rate: 1 instruction/cycle when InstReady=1.
//  - Output: the head is read combinationally from registered storage; InstValid = (Count!=0).
//    - Pop occurs on InstValid & InstReady.
//  - Push and pop in the same cycle: Count unchanged, pointers both advance modulo DEPTH.
//  - Full (Count==DEPTH): no issue. Empty: InstValid=0, and the head fields hold their last value.
//  - Redirect=1 (highest priority):
//    - Count<=0 and both pointers<=0.
//    - A response in flight is squashed (not written).
//    - Any handshake that cycle is ignored; the head is discarded.
//    - FetchPC<=RedirectPC&~3, and no issue that cycle.
//    - Refetch starts the next cycle; new InstValid is 2 cycles after that.
//  - Redirect held several cycles: the queue stays empty and FetchPC tracks RedirectPC.
//  - Redirect during reset is ignored. Reset mid-fill discards everything, including the in-flight read.
// CONFIGURATION
//  PFQ_PERF_EN defined:
//    - Adds outputs FlushCnt[15:0] (counts cycles with Redirect=1).
//    - Adds outputs StallCnt[15:0] (counts cycles with InstReady=1 & InstValid=0).
//    - Both counters saturate at 16'hFFFF and reset to 0.
//  PFQ_PERF_EN undefined: neither port nor counter logic exists; all other behaviour is identical.
// STRUCTURE
//  - Shared package/header cpu_defs: RESET_PC, ILLOP=32'h80000004, XADR=32'h80000008,
//    and the PC+4 kernel-bit-preserving increment function.
//  - Sub-module pfq_storage: DEPTH x 96-bit register array with head/tail pointers,
//    push, pop and flush.
//  - The top level holds FetchPC, the in-flight/squash flag, issue credit and the perf counters.
// TESTING
//  - Reset then hold InstReady=1, ROM = address-as-data:
//    - RomAddr sequence is 80000000, 80000004, ...
//    - First InstValid 2 cycles after the first RomRd.
//    - Instruct==InstPC; InstPC4=InstPC+4.
//  - InstReady=0 for 10 cycles: Count saturates at 4 and RomRd drops.
//    Raising InstReady drains 80000000..8000000C in order with no loss or duplicate.
//  - Redirect=1 with RedirectPC=00400013 while a read is in flight:
//    - Next cycle InstValid=0 and Count=0.
//    - Next RomAddr=00400010; the squashed data never appears.
//  - FetchPC=FFFFFFFC running: the next RomAddr is 80000000 (bit 31 kept),
//    and InstPC4 of FFFFFFFC is 80000000.
//  - Assert Reset low mid-stream between edges:
//    outputs go to reset values immediately; after release fetch restarts at 80000000.
//  - With PFQ_PERF_EN: 3 redirect cycles plus 5 starved cycles give FlushCnt=3, StallCnt=5.
//    Forcing 70000 redirect cycles gives FlushCnt=FFFF.

Source files
------------

// File: rtl/inst_prefetch_queue_pkg.sv
// Shared CPU definitions for the instruction prefetch queue: fixed vectors,
// queue entry layout and the kernel-bit-preserving PC increment.
package inst_prefetch_queue_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP    = 32'h8000_0004;
  localparam logic [31:0] XADR     = 32'h8000_0008;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } pfqEntry_t;

  // Bit 31 is the kernel bit and never changes; the low 31 bits wrap.
  function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/inst_prefetch_queue_storage.sv
// DEPTH-entry register FIFO holding {instr, pc, pc+4} for the prefetch queue.
// Flush clears occupancy and both pointers and wins over push/pop.
module pfq_storage
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  pfqEntry_t               wrData_i,
  output pfqEntry_t               rdData_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PW = $clog2(DEPTH);

  pfqEntry_t         mem_q [DEPTH];
  logic [PW-1:0]     rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d, headIdx;
  logic [PW:0]       count_q, count_d;

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (push_i) wrPtr_d = wrPtr_q + PW'(1);
      if (pop_i)  rdPtr_d = rdPtr_q + PW'(1);
      if (push_i && !pop_i)      count_d = count_q + (PW+1)'(1);
      else if (pop_i && !push_i) count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      if (push_i && !flush_i) mem_q[wrPtr_q] <= wrData_i;
    end
  end

  // When empty, show the slot just behind the head so the fields keep the last popped entry.
  assign headIdx  = (count_q == '0) ? rdPtr_q - PW'(1) : rdPtr_q;
  assign rdData_o = mem_q[headIdx];
  assign count_o  = count_q;

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch stage: sequential ROM fetch into a small queue, drained by decode.
// Optional macro PFQ_PERF_EN adds saturating flush/stall cycle counters.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = inst_prefetch_queue_pkg::RESET_PC
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic                    romRd_o,
  output logic [31:0]             romAddr_o,
  input  logic [31:0]             romData_i,
  input  logic                    redirect_i,
  input  logic [31:0]             redirectPc_i,
  output logic                    instValid_o,
  input  logic                    instReady_i,
  output logic [31:0]             instruct_o,
  output logic [31:0]             instPc_o,
  output logic [31:0]             instPc4_o,
  output logic [$clog2(DEPTH):0]  count_o
`ifdef PFQ_PERF_EN
  ,
  output logic [15:0]             flushCnt_o,
  output logic [15:0]             stallCnt_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0] fetchPc_q, fetchPc_d, issuedPc_q, issuedPc_d;
  logic        inflight_q, inflight_d;
  logic        issue, push, pop;
  logic [CW:0] occupancy;
  pfqEntry_t   wrEntry, headEntry;

  // Credit counts queued plus in-flight entries only, so a full queue can never overflow.
  assign occupancy   = {1'b0, count_o} + {{CW{1'b0}}, inflight_q};
  assign issue       = !redirect_i && (occupancy < (CW+1)'(DEPTH));
  assign romRd_o     = issue && rst_ni;
  assign romAddr_o   = fetchPc_q;
  assign instValid_o = (count_o != '0);
  assign push        = inflight_q && !redirect_i;
  assign pop         = instValid_o && instReady_i && !redirect_i;
  assign wrEntry     = '{instr: romData_i, pc: issuedPc_q, pc4: pcPlus4(issuedPc_q)};

  always_comb begin
    fetchPc_d  = fetchPc_q;
    issuedPc_d = issuedPc_q;
    inflight_d = 1'b0;
    if (redirect_i) begin
      fetchPc_d = {redirectPc_i[31:2], 2'b00};
    end else if (issue) begin
      fetchPc_d  = pcPlus4(fetchPc_q);
      issuedPc_d = fetchPc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetchPc_q  <= RESET_PC;
      issuedPc_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetchPc_q  <= fetchPc_d;
      issuedPc_q <= issuedPc_d;
      inflight_q <= inflight_d;
    end
  end

  pfq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (redirect_i),
    .push_i   (push),
    .pop_i    (pop),
    .wrData_i (wrEntry),
    .rdData_o (headEntry),
    .count_o  (count_o)
  );

  assign instruct_o = headEntry.instr;
  assign instPc_o   = headEntry.pc;
  assign instPc4_o  = headEntry.pc4;

`ifdef PFQ_PERF_EN
  logic [15:0] flushCnt_q, flushCnt_d, stallCnt_q, stallCnt_d;

  always_comb begin
    flushCnt_d = flushCnt_q;
    stallCnt_d = stallCnt_q;
    if (redirect_i && (flushCnt_q != 16'hFFFF))
      flushCnt_d = flushCnt_q + 16'd1;
    if (instReady_i && !instValid_o && (stallCnt_q != 16'hFFFF))
      stallCnt_d = stallCnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flushCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      flushCnt_q <= flushCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign flushCnt_o = flushCnt_q;
  assign stallCnt_o = stallCnt_q;
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_inst_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        romRd, instValid, redirect, instReady;
  logic [31:0] romAddr, romData, redirectPc, instruct, instPc, instPc4;
  logic [2:0]  count;
`ifdef PFQ_PERF_EN
  logic [15:0] flushCnt, stallCnt;
`endif

  always #5 clk = ~clk;

  inst_prefetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .romRd_o      (romRd),
    .romAddr_o    (romAddr),
    .romData_i    (romData),
    .redirect_i   (redirect),
    .redirectPc_i (redirectPc),
    .instValid_o  (instValid),
    .instReady_i  (instReady),
    .instruct_o   (instruct),
    .instPc_o     (instPc),
    .instPc4_o    (instPc4),
    .count_o      (count)
`ifdef PFQ_PERF_EN
    ,
    .flushCnt_o   (flushCnt),
    .stallCnt_o   (stallCnt)
`endif
  );

  // Synchronous ROM owned by the bench: data is addr ^ romKey, one cycle after the strobe.
  logic [31:0] romKey = 32'h0;
  initial romData = 32'h0;
  always @(posedge clk) if (romRd) romData <= romAddr ^ romKey;

  int passCount = 0;
  int totalCount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  // Reference model: a queue of expected entries plus one pending ROM read.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } mEntry_t;

  mEntry_t     mQ[$];
  bit          mPending;
  logic [31:0] mPendAddr, mFetch;
  int          mFlush, mStall;

  function automatic logic [31:0] pcNext(input logic [31:0] a);
    return (a & 32'h8000_0000) | ((a + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  function automatic bit mIssue(input logic redir);
    return !redir && ((mQ.size() + int'(mPending)) < DEPTH);
  endfunction

  task automatic modelReset();
    mQ.delete();
    mPending  = 0;
    mPendAddr = 32'h0;
    mFetch    = 32'h8000_0000;
    mFlush    = 0;
    mStall    = 0;
  endtask

  task automatic checkOutput();
    check("count", 32'(count), 32'(mQ.size()));
    check("instValid", 32'(instValid), 32'(mQ.size() != 0));
    check("romRd", 32'(romRd), 32'(mIssue(redirect)));
    check("romAddr", romAddr, mFetch);
    if (mQ.size() != 0) begin
      check("instruct", instruct, mQ[0].instr);
      check("instPc", instPc, mQ[0].pc);
      check("instPc4", instPc4, pcNext(mQ[0].pc));
    end
`ifdef PFQ_PERF_EN
    check("flushCnt", 32'(flushCnt), 32'(mFlush));
    check("stallCnt", 32'(stallCnt), 32'(mStall));
`endif
  endtask

  task automatic modelStep();
    bit iss, valid;
    iss   = mIssue(redirect);
    valid = (mQ.size() != 0);
    if (redirect && mFlush < 65535) mFlush++;
    if (instReady && !valid && mStall < 65535) mStall++;
    if (redirect) begin
      mQ.delete();
      mPending = 0;
      mFetch   = redirectPc & 32'hFFFF_FFFC;
    end else begin
      if (valid && instReady) void'(mQ.pop_front());
      if (mPending) mQ.push_back('{instr: mPendAddr ^ romKey, pc: mPendAddr});
      mPending  = iss;
      mPendAddr = mFetch;
      if (iss) mFetch = pcNext(mFetch);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc,
                               input bit doCheck);
    @(negedge clk);
    instReady  = rdy;
    redirect   = redir;
    redirectPc = rpc;
    #1;
    if (doCheck) checkOutput();
    modelStep();
  endtask

  // Redirect is held during reset to show it is ignored; release lands just after an edge.
  task automatic doReset();
    rst_ni     = 1'b0;
    instReady  = 1'b0;
    redirect   = 1'b1;
    redirectPc = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    check("rst.romRd", 32'(romRd), 32'h0);
    check("rst.instValid", 32'(instValid), 32'h0);
    check("rst.count", 32'(count), 32'h0);
    check("rst.instruct", instruct, 32'h0);
    check("rst.instPc", instPc, 32'h0);
    check("rst.instPc4", instPc4, 32'h0);
`ifdef PFQ_PERF_EN
    check("rst.flushCnt", 32'(flushCnt), 32'h0);
    check("rst.stallCnt", 32'(stallCnt), 32'h0);
`endif
    redirect = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    modelReset();
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        expRd;
    logic [31:0] expAddr;
    logic        expValid;
    logic [2:0]  expCount;
    logic [31:0] expPc;
    logic [31:0] expPc4;
  } vec_t;

  initial begin
    vec_t vecs[10];
    vecs[0] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8000_0000, 1'b0, 3'd0, 32'h0,        32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8000_0004, 1'b0, 3'd0, 32'h0,        32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8000_0008, 1'b1, 3'd1, 32'h8000_0000, 32'h8000_0004};
    vecs[3] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8000_000C, 1'b1, 3'd1, 32'h8000_0004, 32'h8000_0008};
    vecs[4] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8000_0010, 1'b1, 3'd1, 32'h8000_0008, 32'h8000_000C};
    vecs[5] = '{1'b1, 1'b1, 32'h0040_0013, 1'b0, 32'h8000_0014, 1'b1, 3'd1, 32'h8000_000C, 32'h8000_0010};
    vecs[6] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0010, 1'b0, 3'd0, 32'h0,        32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0014, 1'b0, 3'd0, 32'h0,        32'h0};
    vecs[8] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0018, 1'b1, 3'd1, 32'h0040_0010, 32'h0040_0014};
    vecs[9] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_001C, 1'b1, 3'd1, 32'h0040_0014, 32'h0040_0018};

    $display("[TB] directed vector table");
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rdy, vecs[i].redir, vecs[i].rpc, 1'b0);
      check($sformatf("tbl[%0d].romRd", i), 32'(romRd), 32'(vecs[i].expRd));
      check($sformatf("tbl[%0d].romAddr", i), romAddr, vecs[i].expAddr);
      check($sformatf("tbl[%0d].instValid", i), 32'(instValid), 32'(vecs[i].expValid));
      check($sformatf("tbl[%0d].count", i), 32'(count), 32'(vecs[i].expCount));
      if (vecs[i].expValid) begin
        check($sformatf("tbl[%0d].instPc", i), instPc, vecs[i].expPc);
        check($sformatf("tbl[%0d].instruct", i), instruct, vecs[i].expPc);
        check($sformatf("tbl[%0d].instPc4", i), instPc4, vecs[i].expPc4);
      end
    end

    $display("[TB] backpressure fill and drain");
    doReset();
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    check("full.count", 32'(count), 32'd4);
    check("full.romRd", 32'(romRd), 32'h0);
    check("full.headPc", instPc, 32'h8000_0000);
    repeat (12) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    $display("[TB] kernel-bit wrap");
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    check("wrap.firstAddr", romAddr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    check("wrap.nextAddr", romAddr, 32'h8000_0000);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    check("wrap.headPc", instPc, 32'hFFFF_FFFC);
    check("wrap.headPc4", instPc4, 32'h8000_0000);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    $display("[TB] asynchronous reset mid-stream");
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midRst.romRd", 32'(romRd), 32'h0);
    check("midRst.instValid", 32'(instValid), 32'h0);
    check("midRst.count", 32'(count), 32'h0);
    check("midRst.instPc", instPc, 32'h0);
    check("midRst.romAddr", romAddr, 32'h8000_0000);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    modelReset();
    repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

`ifdef PFQ_PERF_EN
    $display("[TB] performance counters");
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0100, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0100, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    check("perf.flushCnt", 32'(flushCnt), 32'd3);
    check("perf.stallCnt", 32'(stallCnt), 32'd5);
    doReset();
    repeat (70000) applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    check("perf.flushSat", 32'(flushCnt), 32'h0000_FFFF);
`endif

    $display("[TB] randomized traffic");
    doReset();
    romKey = 32'hA5C3_0F1E;
    for (int n = 0; n < 400; n++) begin
      logic rdy, redir;
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      applyStimulus(rdy, redir, $urandom, 1'b1);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
